hazard_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage RISC-V core. It sits next to the forwarding unit and covers the hazards that forwarding cannot resolve:
- load-use dependencies (one-bubble stall);
- taken-branch/jump redirects (D/E flush);
- data-memory wait states (whole-pipe freeze via a timeout-guarded FSM).

All stall and flush enables come from this block.

---
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/flush controller for the 5-stage RISC-V pipeline.
//
// Handles the hazards that forwarding cannot resolve:
//   - load-use dependency  : one bubble (StallF/StallD + FlushE)
//   - taken branch/jump    : flush Decode and Execute
//   - data-memory waits    : freeze the whole pipe, guarded by a timeout
//                            that parks the FSM in a sticky error state
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   Rs1D, Rs2D              source registers of the Decode instruction
//   RdE, MemReadE           destination / load flag of the Execute instruction
//   PCSrcE                  taken branch/jump resolved in Execute
//   DMemReqM, DMemAckM      data-memory request / completion in Memory stage
//   StallF..StallW, FlushD, FlushE   pipeline register enables (combinational)
//   MemErr                  sticky memory-timeout error (registered)
//   LoadStallCnt, MemWaitCnt, FlushCnt   saturating perf counters
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> the three PERF_W saturating counters are built
//   undefined -> counter outputs are tied to 0, no counter flops
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdE,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic              DMemReqM,
    input  logic              DMemAckM,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              StallW,
    output logic              MemErr,
    output logic [PERF_W-1:0] LoadStallCnt,
    output logic [PERF_W-1:0] MemWaitCnt,
    output logic [PERF_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] wait_cnt;

    logic lwhaz, memwait, freeze;
    logic win_lw, win_br;

    assign lwhaz   = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign memwait = DMemReqM & ~DMemAckM;
    // In MEM_WAIT only the ack releases the freeze; a dropped request without
    // an ack is treated as still waiting.
    assign freeze  = ((state == MEM_WAIT) & ~DMemAckM) |
                     ((state == RUN) & memwait) |
                     (state == ERR);

    // Winning conditions below freeze, used by the outputs and the counters.
    assign win_br = ~freeze & PCSrcE;
    assign win_lw = ~freeze & ~PCSrcE & lwhaz;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (win_br) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (win_lw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memwait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (DMemAckM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        state  <= ERR;
                        MemErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    // Terminal until reset.
                    state  <= ERR;
                    MemErr <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic memfrz;
    // Freeze cycles are only counted while waiting, not once parked in ERR.
    assign memfrz = freeze & (state != ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LoadStallCnt <= '0;
            MemWaitCnt   <= '0;
            FlushCnt     <= '0;
        end else begin
            if (win_lw && (LoadStallCnt != '1)) LoadStallCnt <= LoadStallCnt + 1'b1;
            if (memfrz && (MemWaitCnt != '1))   MemWaitCnt   <= MemWaitCnt + 1'b1;
            if (win_br && (FlushCnt != '1))     FlushCnt     <= FlushCnt + 1'b1;
        end
    end
`else
    assign LoadStallCnt = '0;
    assign MemWaitCnt   = '0;
    assign FlushCnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Outputs are packed as
// {StallF,StallD,FlushD,StallE,FlushE,StallM,StallW}.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        MemReadE, PCSrcE, DMemReqM, DMemAckM;
    logic        StallF, StallD, FlushD, StallE, FlushE, StallM, StallW, MemErr;
    logic [31:0] LoadStallCnt, MemWaitCnt, FlushCnt;
    logic [6:0]  outs;

    int n_run = 0;
    int n_fail = 0;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FRZ  = 7'b1101011;
    localparam logic [6:0] BR   = 7'b0010100;
    localparam logic [6:0] LW   = 7'b1100100;

    hazard_ctrl #(.MEM_TIMEOUT(16), .TO_W(5), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .MemReadE(MemReadE),
        .PCSrcE(PCSrcE), .DMemReqM(DMemReqM), .DMemAckM(DMemAckM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
        .FlushE(FlushE), .StallM(StallM), .StallW(StallW), .MemErr(MemErr),
        .LoadStallCnt(LoadStallCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    assign outs = {StallF, StallD, FlushD, StallE, FlushE, StallM, StallW};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        MemReadE = 1'b0; PCSrcE = 1'b0; DMemReqM = 1'b0; DMemAckM = 1'b0;
    endtask

    // Expected perf counter value: real count when built, else tied 0.
    function automatic logic [31:0] pc(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_outs", 32'(outs), 32'(NONE));
        chk("rst_memerr", 32'(MemErr), 32'd0);
        chk("rst_lscnt", LoadStallCnt, 32'd0);
        chk("rst_mwcnt", MemWaitCnt, 32'd0);
        chk("rst_flcnt", FlushCnt, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Load-use via rs1: one bubble, then clean.
        MemReadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; #1;
        chk("lw_rs1", 32'(outs), 32'(LW));
        cyc(); idle(); #1;
        chk("lw_after", 32'(outs), 32'(NONE));
        cyc();

        // x0 never hazards; rs2 path; no match; not a load.
        MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0; #1;
        chk("x0_guard", 32'(outs), 32'(NONE));
        RdE = 5'd5; Rs1D = 5'd3; Rs2D = 5'd5; #1;
        chk("lw_rs2", 32'(outs), 32'(LW));
        cyc();
        Rs2D = 5'd4; #1;
        chk("lw_nomatch", 32'(outs), 32'(NONE));
        MemReadE = 1'b0; Rs1D = 5'd5; #1;
        chk("lw_notload", 32'(outs), 32'(NONE));
        cyc(); idle();

        // Branch beats load-use.
        PCSrcE = 1'b1; MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; #1;
        chk("br_over_lw", 32'(outs), 32'(BR));
        cyc(); idle(); #1;

        // Memory wait: 3 frozen cycles, ack cycle not frozen.
        DMemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_frz%0d", i), 32'(outs), 32'(FRZ));
            cyc();
        end
        DMemAckM = 1'b1; #1;
        chk("mw_ack", 32'(outs), 32'(NONE));
        cyc(); idle(); #1;
        chk("mw_run", 32'(outs), 32'(NONE));
        chk("cnt_ls1", LoadStallCnt, pc(2));
        chk("cnt_mw1", MemWaitCnt, pc(3));
        chk("cnt_fl1", FlushCnt, pc(1));

        // Zero-wait access: no freeze, stays in RUN.
        DMemReqM = 1'b1; DMemAckM = 1'b1; #1;
        chk("zw_nofrz", 32'(outs), 32'(NONE));
        cyc(); idle(); #1;
        chk("zw_run", 32'(outs), 32'(NONE));

        // Branch during freeze; request drop without ack keeps waiting.
        DMemReqM = 1'b1; PCSrcE = 1'b1; MemReadE = 1'b1; RdE = 5'd9; Rs1D = 5'd9; #1;
        chk("bf_frz0", 32'(outs), 32'(FRZ));
        cyc();
        DMemReqM = 1'b0; #1;
        chk("bf_frz1", 32'(outs), 32'(FRZ));
        cyc();
        DMemAckM = 1'b1; #1;
        chk("bf_ack", 32'(outs), 32'(BR));
        cyc(); idle(); #1;
        chk("cnt_mw2", MemWaitCnt, pc(5));
        chk("cnt_fl2", FlushCnt, pc(2));
        chk("cnt_ls2", LoadStallCnt, pc(2));

        // Timeout: error after the 16th edge of continuous waiting.
        DMemReqM = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 chk($sformatf("to_frz%0d", i), 32'(outs), 32'(FRZ));
            chk($sformatf("to_noerr%0d", i), 32'(MemErr), 32'd0);
            cyc();
        end
        chk("to_err", 32'(MemErr), 32'd1);
        DMemReqM = 1'b0; DMemAckM = 1'b1; PCSrcE = 1'b1; #1;
        chk("err_frz", 32'(outs), 32'(FRZ));
        cyc(); cyc();
        chk("err_sticky", 32'(MemErr), 32'd1);
        chk("err_frz2", 32'(outs), 32'(FRZ));
        chk("cnt_mw3", MemWaitCnt, pc(21));
        idle(); #2;

        // Async reset mid-cycle clears error and freeze.
        rst_n = 1'b0; #1;
        chk("arst_err", 32'(MemErr), 32'd0);
        chk("arst_outs", 32'(outs), 32'(NONE));
        chk("arst_mw", MemWaitCnt, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset asserted mid-wait drops straight back to RUN.
        DMemReqM = 1'b1;
        cyc(); cyc();
        DMemReqM = 1'b0; #1;
        chk("mid_frz", 32'(outs), 32'(FRZ));
        rst_n = 1'b0; #1;
        chk("mid_rst", 32'(outs), 32'(NONE));
        cyc();
        rst_n = 1'b1;
        cyc(); #1;
        chk("mid_run", 32'(outs), 32'(NONE));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
